// File: rtl/sm4_mode_ctrl.sv
// SM4 block-mode wrapper: packs 32-bit words into 128-bit blocks, drives an external
// cipher core and unpacks results. CBC chaining is built only when SM4_MODE_CBC_EN is defined.
module sm4_mode_ctrl #(
    parameter int word_width_p = 32,
    parameter int group_size_p = 128
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    init_i,
    input  logic [group_size_p-1:0] key_i,
    input  logic [group_size_p-1:0] iv_i,
    input  logic                    mode_i,
    input  logic                    decode_i,
    input  logic [word_width_p-1:0] data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [word_width_p-1:0] data_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic [group_size_p-1:0] core_content_o,
    output logic [group_size_p-1:0] core_key_o,
    output logic                    core_decode_o,
    output logic                    core_v_o,
    input  logic                    core_ready_i,
    input  logic [group_size_p-1:0] core_crypt_i,
    input  logic                    core_v_i,
    output logic                    core_yumi_o
);
    localparam int Words = group_size_p / word_width_p;
    localparam int CntW  = $clog2(Words);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    typedef logic [Words-1:0][word_width_p-1:0] blk_t;

    logic [1:0]              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    blk_t                    blk_q, blk_d, out_q, out_d;
    logic [group_size_p-1:0] key_q, key_d;
    logic                    dec_q, dec_d;
    logic [group_size_p-1:0] result;
    logic                    cfg_ld, last;

    assign last   = (cnt_q == {CntW{1'b1}});
    assign cfg_ld = init_i && (state_q == S_COLLECT) && (cnt_q == '0);

`ifdef SM4_MODE_CBC_EN
    logic [group_size_p-1:0] chain_q, chain_d;
    logic                    mode_q, mode_d;

    assign core_content_o = (mode_q && !dec_q) ? (blk_q ^ chain_q) : blk_q;
    assign result         = (mode_q && dec_q) ? (core_crypt_i ^ chain_q) : core_crypt_i;

    always_comb begin
        mode_d  = mode_q;
        chain_d = chain_q;
        if (cfg_ld) begin
            mode_d  = mode_i;
            chain_d = iv_i;
        end else if (state_q == S_WAIT && core_v_i && mode_q) begin
            chain_d = dec_q ? blk_q : core_crypt_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mode_q  <= 1'b0;
            chain_q <= '0;
        end else begin
            mode_q  <= mode_d;
            chain_q <= chain_d;
        end
    end
`else
    logic unused_cbc_cfg;
    assign unused_cbc_cfg = ^{iv_i, mode_i};
    assign core_content_o = blk_q;
    assign result         = core_crypt_i;
`endif

    // Word 0 is the most significant word, hence the inverted counter as index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        out_d   = out_q;
        key_d   = key_q;
        dec_d   = dec_q;
        if (cfg_ld) begin
            key_d = key_i;
            dec_d = decode_i;
        end
        case (state_q)
            S_COLLECT: if (v_i) begin
                blk_d[~cnt_q] = data_i;
                cnt_d         = cnt_q + 1'b1;
                if (last) state_d = S_ISSUE;
            end
            S_ISSUE: if (core_ready_i) state_d = S_WAIT;
            S_WAIT: if (core_v_i) begin
                out_d   = result;
                state_d = S_DRAIN;
            end
            S_DRAIN: if (yumi_i) begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = S_COLLECT;
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            blk_q   <= '0;
            out_q   <= '0;
            key_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
        end
    end

    assign ready_o       = (state_q == S_COLLECT);
    assign core_v_o      = (state_q == S_ISSUE);
    assign core_yumi_o   = (state_q == S_WAIT) && core_v_i;
    assign v_o           = (state_q == S_DRAIN);
    assign data_o        = out_q[~cnt_q];
    assign core_key_o    = key_q;
    assign core_decode_o = dec_q;

endmodule

// File: doc/sm4_mode_ctrl.md
SM4_MODE_CTRL -- requirements
Module: sm4_mode_ctrl

Interface
REQ-001 SHALL have parameter word_width_p, default 32, width of one stream word.
REQ-002 SHALL have parameter group_size_p, default 128, width of one SM4 block (4 words).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- init_i  in  1  load configuration and restart the chain.
- key_i  in  128  cipher key.
- iv_i  in  128  CBC initial vector.
- mode_i  in  1  0 = ECB, 1 = CBC.
- decode_i  in  1  0 = encrypt, 1 = decrypt.
- data_i  in  32  input word.
- v_i  in  1  data_i valid.
- ready_o  out  1  accepting input words.
- data_o  out  32  output word.
- v_o  out  1  data_o valid.
- yumi_i  in  1  data_o consumed.
- core_content_o  out  128  block to cipher core.
- core_key_o  out  128  key to cipher core.
- core_decode_o  out  1  core direction.
- core_v_o  out  1  block valid to core.
- core_ready_i  in  1  core accepting.
- core_crypt_i  in  128  core result.
- core_v_i  in  1  core result valid.
- core_yumi_o  out  1  core result consumed.

Function
REQ-005 SHALL implement states eCollect, eIssue, eWait and eDrain, plus a 2-bit word counter.
REQ-006 eCollect: ready_o = 1. On v_i, store data_i as word[count] and increment count. Word 0 maps to bits [127:96]. On the 4th word, go to eIssue with count = 0.
REQ-007 init_i SHALL be honoured only in eCollect with count = 0, and ignored otherwise. It latches key_i, mode_i and decode_i, and sets chain_r = iv_i. If init_i and v_i arrive in the same cycle, the new configuration applies to that block.
REQ-008 eIssue: core_v_o = 1. core_content_o SHALL be:
- P ^ chain_r for CBC encrypt;
- the collected block otherwise.
Go to eWait on core_ready_i. core_v_o rises the cycle after the 4th word is accepted.
REQ-009 eWait: core_yumi_o = core_v_i. When core_v_i is high, capture the output block and go to eDrain. The output block SHALL be:
- core_crypt_i for ECB and for CBC encrypt;
- core_crypt_i ^ chain_r for CBC decrypt.
REQ-010 CBC chain update at core_v_i:
- encrypt: chain_r <= core_crypt_i;
- decrypt: chain_r <= the collected ciphertext block.
ECB SHALL leave chain_r unchanged.
REQ-011 eDrain: v_o = 1 and data_o = output word[count]. Each yumi_i increments count. The 4th yumi_i returns to eCollect with count = 0. data_o SHALL be held stable while yumi_i is low.
REQ-012 ready_o SHALL be 0 outside eCollect; there is no collect/drain overlap. yumi_i outside eDrain and core_v_i outside eWait SHALL be ignored.
REQ-013 core_key_o and core_decode_o SHALL come from the latched configuration and stay constant between init_i pulses.

Reset
REQ-014 reset_i SHALL force the following immediately, including mid-operation:
- state = eCollect, count = 0;
- chain_r, key, mode, decode and all data registers = 0;
- ready_o = 1; v_o, core_v_o and core_yumi_o = 0; data_o = 0.
REQ-015 After reset deassertion, the first accepted word SHALL be word 0.

Configuration
REQ-016 Macro SM4_MODE_CBC_EN defined: ECB and CBC both supported as above.
REQ-017 Macro undefined: chain_r and its XOR paths are absent, mode_i is ignored, all blocks are processed ECB, and iv_i is unused.

Verification
REQ-018 ECB encrypt: init (key 0123456789abcdeffedcba9876543210), feed 01234567, 89abcdef, fedcba98, 76543210 -> outputs 681edf34, d206965e, 86b3e94f, 536e4246.
REQ-019 ECB decrypt: same key, feed 681edf34, d206965e, 86b3e94f, 536e4246 -> outputs 01234567, 89abcdef, fedcba98, 76543210.
REQ-020 CBC encrypt, IV = 0, same key, same plaintext twice:
- block 1 output equals the ECB ciphertext;
- block 2 core_content_o = 693d9a53 5bad5bb1 786f53d7 253a7056.
Then CBC decrypt of both ciphertexts with IV = 0 -> the original plaintext twice.
REQ-021 Backpressure: hold yumi_i low for 5 cycles in eDrain, and core_ready_i low for 3 cycles in eIssue -> data_o and core_content_o stay stable, and no words are lost or duplicated.
REQ-022 Reset in eWait after 2 words of the next block -> ready_o = 1 and v_o = 0 immediately. A fresh init plus 4 words -> correct ECB result.
REQ-023 Macro undefined, mode_i = 1, two identical plaintext blocks -> two identical ciphertexts 681edf34 d206965e 86b3e94f 536e4246.
